multi_port_fifo: RTL
====================

Name: multi_port_fifo

Overview:
- Superscalar successor to the single-port ready/valid FIFO.
- Accepts up to N_ENQ entries and delivers up to N_DEQ entries per cycle, each in lane order.
- Supports any depth (power of two not required), a synchronous flush, and an exact occupancy count.
- Sits between fetch/decode and dispatch queues, where multiple instructions move per cycle.

Parameters:
- ENTRY_WIDTH, 32: bits per entry.
- N_ENTRIES, 8: queue depth; must be >= max(N_ENQ, N_DEQ) and >= 2.
- N_ENQ, 2: enqueue lanes per cycle; >= 1.
- N_DEQ, 2: dequeue lanes per cycle; >= 1.
- CNT_WIDTH, $clog2(N_ENTRIES+1): localparam, occupancy width.
- ALMOST_FULL_THRESH, 2: free-slot threshold for almost_full; only used with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of the contents.
- enq_valid  in  N_ENQ  per-lane enqueue request.
- enq_data  in  N_ENQ*ENTRY_WIDTH  lane i occupies bits [i*ENTRY_WIDTH +: ENTRY_WIDTH].
- enq_ready  out  N_ENQ  lane i accepted if valid.
- deq_ready  in  N_DEQ  per-lane consumer ready.
- deq_valid  out  N_DEQ  lane j holds a valid entry.
- deq_data  out  N_DEQ*ENTRY_WIDTH  lane j is the j-th oldest entry.
- count  out  CNT_WIDTH  current occupancy, 0..N_ENTRIES.
- almost_full  out  1  present only with the optional feature.

Behaviour:
- State: head pointer, tail pointer (each 0..N_ENTRIES-1, wrapping modulo N_ENTRIES, not power-of-two masking), registered occupancy cnt, entry array.
- Reset (rst=1): head=tail=cnt=0.
  - Outputs after reset: count=0, deq_valid=0, enq_ready all 1.
  - Entry contents are don't-care; they need no reset.
- rst has priority over flush. flush has the same effect as rst on pointers and cnt, and overrides any enq/deq in that cycle.
- enq_ready[i] = (N_ENTRIES - cnt) > i. This is combinational from registered state only, with no dependence on deq in the same cycle.
- deq_valid[j] = cnt > j. deq_data[j] = mem[(head+j) mod N_ENTRIES]. Read is combinational from registers, giving 0-cycle read latency.
- Lane-prefix rule for enqueue:
  - n_enq = number of leading lanes, starting at lane 0, with enq_valid & enq_ready both 1.
  - Lanes after the first lane that fails are ignored, even if valid&ready.
  - Producers must present valid lanes contiguously from lane 0.
- The same lane-prefix rule applies to dequeue: n_deq = leading count of deq_valid & deq_ready.
- Each clock edge (no rst/flush):
  - mem[(tail+i) mod N_ENTRIES] <= enq_data[i] for i < n_enq.
  - tail += n_enq (mod).
  - head += n_deq (mod).
  - cnt <= cnt + n_enq - n_deq.
- Simultaneous enq and deq are allowed.
  - Freed slots become visible to enq_ready only next cycle (no same-cycle recycle).
  - There is no enq-to-deq bypass: an entry enqueued at edge k is first visible on deq at cycle k+1.
- Full (cnt=N_ENTRIES): enq_ready=0 on all lanes; a deq in the same cycle still proceeds.
- Empty (cnt=0): deq_valid=0; deq_ready is ignored.
- Wrap-around: multi-lane writes and reads that straddle index N_ENTRIES-1 → 0 must split correctly.
- Invariant: 0 <= cnt <= N_ENTRIES. An accepted operation can never violate it.

Optional Feature:
- Macro: MULTI_PORT_FIFO_ALMOST_FULL_EN.
- Defined: port almost_full exists and is registered. It is 1 the cycle after the next-state free slots (N_ENTRIES - cnt_next) < ALMOST_FULL_THRESH, and 0 after rst or flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_add(ptr, inc, depth), a modulo add without power-of-two assumption;
  - function leading_ones_count(vec);
  - no typedefs beyond logic vectors.
- One natural sub-module: prefix_count, parametrised by WIDTH. It is combinational, takes valid & ready, outputs the leading-ones count, and is instantiated twice (enq, deq).

Test Plan:
- Reset then idle: rst=1 for 2 cycles → count=0, deq_valid=00, enq_ready=11; hold 5 idle cycles, no change.
- Fill with N_ENTRIES=6, N_ENQ=2: enqueue pairs A0..A5 over 3 cycles with deq_ready=00 → count=6, enq_ready=00. Present a 4th pair → rejected, count stays 6.
- Wrap and order with N_ENTRIES=6: enq 2/cycle and deq 2/cycle for 10 cycles, values 0..19 → deq_data lane0/lane1 stream in order 0,1,2,... through the 5→0 wrap; count steady at 2 after warm-up.
- Prefix rule: enq_valid=10 (lane1 only) → nothing accepted, count unchanged. deq_ready=10 with count=3 → no dequeue.
- Simultaneous at full: count=6, enq_valid=11, deq_ready=11 → n_enq=0, n_deq=2, count=4 next cycle. The following cycle enq of 2 is accepted → count=6.
- Flush mid-stream: count=4, assert flush together with enq_valid=11 and deq_ready=11 → next cycle count=0, deq_valid=00, with almost_full=0 when MULTI_PORT_FIFO_ALMOST_FULL_EN is defined.

Source files
------------

// File: rtl/multi_port_fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: modulo pointer arithmetic for any depth
// and a lane-prefix (leading-ones) counter.
package fifo_pkg;

  // Modulo add that works for non-power-of-two depths; requires ptr < depth and inc <= depth.
  function automatic logic [31:0] ptr_add(
    input logic [31:0] ptr,
    input logic [31:0] inc,
    input logic [31:0] depth
  );
    logic [32:0] sum;
    sum = {1'b0, ptr} + {1'b0, inc};
    if (sum >= {1'b0, depth}) begin
      sum = sum - {1'b0, depth};
    end
    return sum[31:0];
  endfunction

  // Number of consecutive 1s starting at bit 0, looking at the low `width` bits only.
  function automatic logic [31:0] leading_ones_count(
    input logic [31:0] vec,
    input int          width
  );
    logic [31:0] n;
    logic        run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < width && run) begin
        if (vec[i]) begin
          n = n + 32'd1;
        end else begin
          run = 1'b0;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/multi_port_fifo_prefix_count.sv
// Combinational lane-prefix counter: how many lanes, from lane 0 upward,
// have both valid and ready set before the first lane that does not.
module prefix_count
  import fifo_pkg::*;
#(
  parameter  int WIDTH = 2,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_valid,
  input  logic [WIDTH-1:0] i_ready,
  output logic [CW-1:0]    o_count
);

  logic [31:0] w_vec;

  assign w_vec   = 32'(i_valid & i_ready);
  assign o_count = CW'(leading_ones_count(w_vec, WIDTH));

endmodule

// File: rtl/multi_port_fifo.sv
// Superscalar FIFO: up to N_ENQ pushes and N_DEQ pops per cycle, any depth, exact count.
// Optional registered almost_full output when MULTI_PORT_FIFO_ALMOST_FULL_EN is defined.
module multi_port_fifo
  import fifo_pkg::*;
#(
  parameter  int ENTRY_WIDTH        = 32,
  parameter  int N_ENTRIES          = 8,
  parameter  int N_ENQ              = 2,
  parameter  int N_DEQ              = 2,
  parameter  int ALMOST_FULL_THRESH = 2,
  localparam int CNT_WIDTH          = $clog2(N_ENTRIES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [N_ENQ-1:0]             enq_valid,
  input  logic [N_ENQ*ENTRY_WIDTH-1:0] enq_data,
  output logic [N_ENQ-1:0]             enq_ready,
  input  logic [N_DEQ-1:0]             deq_ready,
  output logic [N_DEQ-1:0]             deq_valid,
  output logic [N_DEQ*ENTRY_WIDTH-1:0] deq_data,
  output logic [CNT_WIDTH-1:0]         count
`ifdef MULTI_PORT_FIFO_ALMOST_FULL_EN
  ,
  output logic                         almost_full
`endif
);

  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int ECW   = $clog2(N_ENQ + 1);
  localparam int DCW   = $clog2(N_DEQ + 1);

  // Elaboration-time guard against illegal configurations.
  if (N_ENTRIES < 2 || N_ENTRIES < N_ENQ || N_ENTRIES < N_DEQ ||
      N_ENQ < 1 || N_DEQ < 1 || ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > N_ENTRIES)
  begin : g_bad_params
    $error("multi_port_fifo: illegal parameter combination");
  end

  logic [ENTRY_WIDTH-1:0] r_mem [N_ENTRIES];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic [CNT_WIDTH-1:0]   w_free;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic [PTR_W-1:0]       w_head_next;
  logic [PTR_W-1:0]       w_tail_next;
  logic [ECW-1:0]         w_n_enq;
  logic [DCW-1:0]         w_n_deq;
  logic [PTR_W-1:0]       w_wr_idx [N_ENQ];
  logic [PTR_W-1:0]       w_rd_idx [N_DEQ];

  assign w_free = CNT_WIDTH'(N_ENTRIES) - r_cnt;
  assign count  = r_cnt;

  // Ready/valid depend only on registered occupancy, so a pop never frees a slot for the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_ENQ; gi++) begin : g_enq_lane
      assign enq_ready[gi] = 32'(w_free) > 32'(gi);
      assign w_wr_idx[gi]  = PTR_W'(ptr_add(32'(r_tail), 32'(gi), 32'(N_ENTRIES)));
    end
    for (gi = 0; gi < N_DEQ; gi++) begin : g_deq_lane
      assign deq_valid[gi] = 32'(r_cnt) > 32'(gi);
      assign w_rd_idx[gi]  = PTR_W'(ptr_add(32'(r_head), 32'(gi), 32'(N_ENTRIES)));
      assign deq_data[gi*ENTRY_WIDTH +: ENTRY_WIDTH] = r_mem[w_rd_idx[gi]];
    end
  endgenerate

  prefix_count #(
    .WIDTH (N_ENQ)
  ) u_enq_prefix (
    .i_valid (enq_valid),
    .i_ready (enq_ready),
    .o_count (w_n_enq)
  );

  prefix_count #(
    .WIDTH (N_DEQ)
  ) u_deq_prefix (
    .i_valid (deq_valid),
    .i_ready (deq_ready),
    .o_count (w_n_deq)
  );

  assign w_head_next = PTR_W'(ptr_add(32'(r_head), 32'(w_n_deq), 32'(N_ENTRIES)));
  assign w_tail_next = PTR_W'(ptr_add(32'(r_tail), 32'(w_n_enq), 32'(N_ENTRIES)));
  assign w_cnt_next  = r_cnt + CNT_WIDTH'(w_n_enq) - CNT_WIDTH'(w_n_deq);

  // Entry storage carries no reset; only accepted lanes are written.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < N_ENQ; i++) begin
        if (32'(i) < 32'(w_n_enq)) begin
          r_mem[w_wr_idx[i]] <= enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= w_head_next;
      r_tail <= w_tail_next;
      r_cnt  <= w_cnt_next;
    end
  end

`ifdef MULTI_PORT_FIFO_ALMOST_FULL_EN
  logic r_almost_full;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= 32'(CNT_WIDTH'(N_ENTRIES) - w_cnt_next) < 32'(ALMOST_FULL_THRESH);
    end
  end

  assign almost_full = r_almost_full;
`endif

endmodule
